// File: rtl/flag_shadow_ctrl_if.sv
// flag_shadow_ctrl_if: groups the interrupt request, instruction strobes and
// status/strobe outputs of flag_shadow_ctrl.
//   INTR        - external interrupt request, asynchronous level
//   INSTR_DONE  - instruction-boundary strobe
//   SEI/CLI/RETI- decoded instruction strobes, qualified by INSTR_DONE
//   SHAD_LD     - load-enable for the C/Z shadow registers
//   FLG_RESTORE - copy shadow C/Z back into the live flags
//   INT_TAKEN   - one-cycle pulse: push PC and jump to the vector
//   I_FLAG, PENDING, IN_ISR - interrupt enable, latched request, ISR active
// master drives the requests (control unit side), slave is the controller.
interface flag_shadow_ctrl_if;
   logic INTR;
   logic INSTR_DONE;
   logic SEI;
   logic CLI;
   logic RETI;
   logic SHAD_LD;
   logic FLG_RESTORE;
   logic INT_TAKEN;
   logic I_FLAG;
   logic PENDING;
   logic IN_ISR;

   modport master (
      output INTR, INSTR_DONE, SEI, CLI, RETI,
      input  SHAD_LD, FLG_RESTORE, INT_TAKEN, I_FLAG, PENDING, IN_ISR
   );

   modport slave (
      input  INTR, INSTR_DONE, SEI, CLI, RETI,
      output SHAD_LD, FLG_RESTORE, INT_TAKEN, I_FLAG, PENDING, IN_ISR
   );
endinterface

// File: rtl/flag_shadow_ctrl.sv
// flag_shadow_ctrl: single-level interrupt entry/return sequencer with C/Z
// flag shadowing. INTR is synchronised, rising edges latch PENDING, and an
// enabled request is taken at an instruction boundary via SAVE -> VECTOR ->
// ISR, returning through RESTORE on RETI.
// Ports:
//   CLK   - system clock, rising edge
//   RST_N - synchronous active-low reset
//   bus   - flag_shadow_ctrl_if.slave (requests in, strobes/status out)
module flag_shadow_ctrl #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic               CLK,
   input logic               RST_N,
   flag_shadow_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StSave    = 3'd1,
      StVector  = 3'd2,
      StIsr     = 3'd3,
      StRestore = 3'd4
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   logic                   pending_q, pending_d;
   logic                   i_flag_q, i_flag_d;
   logic                   intr_edge;

   // Rising edge at the synchroniser output.
   assign intr_edge = sync_q[SYNC_STAGES-1] & ~dly_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= StIdle;
         sync_q    <= '0;
         dly_q     <= 1'b0;
         pending_q <= 1'b0;
         i_flag_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.INTR};
         dly_q     <= sync_q[SYNC_STAGES-1];
         pending_q <= pending_d;
         i_flag_q  <= i_flag_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      i_flag_d  = i_flag_q;

      case (state_q)
         StIdle: begin
            if (bus.INSTR_DONE) begin
               if (bus.CLI) begin
                  i_flag_d = 1'b0;
               end else if (bus.SEI) begin
                  i_flag_d = 1'b1;
               end
            end
            if (pending_q && i_flag_q && bus.INSTR_DONE) begin
               state_d = StSave;
            end
         end
         StSave: begin
            i_flag_d  = 1'b0;
            pending_d = 1'b0;
            state_d   = StVector;
         end
         StVector: begin
            state_d = StIsr;
         end
         StIsr: begin
            // SEI ignored here: the shadow holds only one level.
            if (bus.INSTR_DONE && bus.CLI) begin
               i_flag_d = 1'b0;
            end
            if (bus.INSTR_DONE && bus.RETI) begin
               state_d = StRestore;
            end
         end
         StRestore: begin
            i_flag_d = 1'b1;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A new edge beats the clear issued in SAVE.
      if (intr_edge) begin
         pending_d = 1'b1;
      end
   end

   assign bus.SHAD_LD     = (state_q == StSave);
   assign bus.INT_TAKEN   = (state_q == StVector);
   assign bus.FLG_RESTORE = (state_q == StRestore);
   assign bus.IN_ISR      = (state_q == StIsr);
   assign bus.I_FLAG      = i_flag_q;
   assign bus.PENDING     = pending_q;

endmodule

// File: tb/tb_flag_shadow_ctrl.sv
// Directed bench for flag_shadow_ctrl (SYNC_STAGES=2). Each stimulus cycle
// queues the hand-computed output vector expected after the next rising
// edge; an independent monitor compares on the falling edge.
// Vector order: {SHAD_LD, INT_TAKEN, FLG_RESTORE, IN_ISR, I_FLAG, PENDING}.
module tb_flag_shadow_ctrl;

   // Input vector order: {INTR, INSTR_DONE, SEI, CLI, RETI}
   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] ID   = 5'b01000;
   localparam logic [4:0] SEI  = 5'b01100;
   localparam logic [4:0] CLI  = 5'b01010;
   localparam logic [4:0] RETI = 5'b01001;
   localparam logic [4:0] IRQ  = 5'b10000;

   typedef struct {
      int unsigned cyc;
      logic [5:0]  exp;
      string       name;
   } sb_entry_t;

   logic        CLK;
   logic        RST_N;
   int unsigned cyc;
   int          n_checks;
   int          n_fail;
   string       phase;
   sb_entry_t   sb_q[$];

   flag_shadow_ctrl_if bus ();

   flag_shadow_ctrl #(
      .SYNC_STAGES (2)
   ) u_dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Drive one cycle of inputs, then queue the expected post-edge outputs.
   task automatic tick(input logic [4:0] in, input logic [5:0] exp);
      sb_entry_t e;
      {bus.INTR, bus.INSTR_DONE, bus.SEI, bus.CLI, bus.RETI} = in;
      @(posedge CLK);
      #1;
      e.cyc  = cyc;
      e.exp  = exp;
      e.name = phase;
      sb_q.push_back(e);
   endtask

   task automatic tick_n(input int n, input logic [4:0] in, input logic [5:0] exp);
      for (int i = 0; i < n; i++) tick(in, exp);
   endtask

   always @(negedge CLK) begin : monitor
      sb_entry_t  e;
      logic [5:0] act;
      act = {bus.SHAD_LD, bus.INT_TAKEN, bus.FLG_RESTORE, bus.IN_ISR, bus.I_FLAG, bus.PENDING};
      if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
         e = sb_q.pop_front();
         n_checks++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", e.name, cyc, act, e.exp);
         end
      end else if (cyc > 0 && act[5:3] !== 3'b000) begin
         n_checks++;
         n_fail++;
         $display("FAIL stray_strobe cyc=%0d actual=%b required=000", cyc, act[5:3]);
      end
   end

   initial begin
      cyc      = 0;
      n_checks = 0;
      n_fail   = 0;
      RST_N    = 1'b0;

      phase = "reset";
      tick_n(2, NONE, 6'b000000);
      RST_N = 1'b1;

      phase = "basic_entry";
      tick(SEI, 6'b000010);
      tick(IRQ | ID, 6'b000010);
      tick(IRQ | ID, 6'b000010);
      tick(IRQ | ID, 6'b000011);
      tick(ID, 6'b100011);
      tick(ID, 6'b010000);
      tick(ID, 6'b000100);
      tick(ID, 6'b000100);

      phase = "return";
      tick(RETI, 6'b001000);
      tick(ID, 6'b000010);
      tick(ID, 6'b000010);

      phase = "reti_idle";
      tick(RETI, 6'b000010);
      phase = "sei_cli_same";
      tick(SEI | CLI, 6'b000000);

      phase = "masked";
      tick(CLI, 6'b000000);
      tick(IRQ | ID, 6'b000000);
      tick(IRQ | ID, 6'b000000);
      tick(ID, 6'b000001);
      tick(CLI, 6'b000001);
      tick_n(19, ID, 6'b000001);
      tick(SEI, 6'b000011);
      tick(ID, 6'b100011);
      tick(ID, 6'b010000);
      tick(ID, 6'b000100);

      phase = "nest_blocked";
      tick(SEI, 6'b000100);
      tick(IRQ, 6'b000100);
      tick(IRQ, 6'b000100);
      tick(NONE, 6'b000101);
      tick(ID, 6'b000101);
      tick(CLI, 6'b000101);
      tick(RETI, 6'b001001);
      tick(ID, 6'b000011);
      tick(ID, 6'b100011);
      tick(ID, 6'b010000);
      tick(ID, 6'b000100);
      tick(RETI, 6'b001000);
      tick(ID, 6'b000010);

      phase = "edge_at_save";
      tick(CLI, 6'b000000);
      tick(IRQ, 6'b000000);
      tick(NONE, 6'b000000);
      tick(NONE, 6'b000001);
      tick(SEI | IRQ, 6'b000011);
      tick(ID, 6'b100011);
      tick(ID, 6'b010001);
      tick(ID, 6'b000101);
      tick(RETI, 6'b001001);
      tick(ID, 6'b000011);
      tick(ID, 6'b100011);
      tick(ID, 6'b010000);
      tick(ID, 6'b000100);

      phase = "reset_mid_isr";
      RST_N = 1'b0;
      tick(ID, 6'b000000);
      RST_N = 1'b1;
      tick(RETI, 6'b000000);
      tick(ID, 6'b000000);

      phase = "intr_through_reset";
      RST_N = 1'b0;
      tick(IRQ, 6'b000000);
      RST_N = 1'b1;
      tick(IRQ, 6'b000000);
      tick(IRQ, 6'b000000);
      tick(IRQ, 6'b000001);
      tick_n(4, IRQ, 6'b000001);
      tick(IRQ | SEI, 6'b000011);
      tick(IRQ | ID, 6'b100011);
      tick(IRQ | ID, 6'b010000);
      tick(IRQ | ID, 6'b000100);
      tick(IRQ | ID, 6'b000100);
      tick(ID, 6'b000100);

      repeat (2) @(negedge CLK);
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_drain actual=%0d entries left required=0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/flag_shadow_ctrl.md
FLAG_SHADOW_CTRL -- requirements
Module: flag_shadow_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on INTR (legal 2..4).
REQ-002 SHALL have port CLK  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port INTR  input  1  external interrupt request, asynchronous, level.
REQ-005 SHALL have port INSTR_DONE  input  1  instruction-boundary strobe from the control unit.
REQ-006 SHALL have ports SEI, CLI, RETI  input  1 each  decoded instruction strobes, each valid only when INSTR_DONE=1.
REQ-007 SHALL have port SHAD_LD  output  1  load-enable to the C and Z shadow registers.
REQ-008 SHALL have port FLG_RESTORE  output  1  selects shadow values into the live C/Z flags and enables their load.
REQ-009 SHALL have port INT_TAKEN  output  1  one-cycle pulse telling the control unit to push PC and jump to the vector.
REQ-010 SHALL have ports I_FLAG, PENDING, IN_ISR  output  1 each  interrupt enable, latched request, ISR-active status.

Function
REQ-011 SHALL pass INTR through a SYNC_STAGES-deep flop chain plus one delay flop; a 0->1 transition at the chain output sets PENDING.
REQ-012 SHALL raise PENDING exactly SYNC_STAGES+1 rising edges after INTR is first sampled high; INTR held high SHALL set PENDING once only.
REQ-013 SHALL implement states IDLE, SAVE, VECTOR, ISR, RESTORE, one-hot or encoded, with no other reachable state; illegal encodings SHALL return to IDLE.
REQ-014 IDLE: PENDING=1 and I_FLAG=1 and INSTR_DONE=1 -> SAVE; otherwise stay.
REQ-015 SAVE (1 cycle): SHAD_LD=1; I_FLAG and PENDING cleared at exit edge -> VECTOR.
REQ-016 VECTOR (1 cycle): INT_TAKEN=1 -> ISR.
REQ-017 ISR: IN_ISR=1; RETI=1 and INSTR_DONE=1 -> RESTORE; otherwise stay.
REQ-018 RESTORE (1 cycle): FLG_RESTORE=1; I_FLAG set at exit edge -> IDLE.
REQ-019 SHAD_LD, INT_TAKEN, FLG_RESTORE SHALL be high only in SAVE, VECTOR, RESTORE respectively, and never simultaneously.
REQ-020 In IDLE, SEI&INSTR_DONE SHALL set I_FLAG and CLI&INSTR_DONE SHALL clear it; SEI and CLI together -> CLI wins (I_FLAG=0).
REQ-021 In ISR, SEI SHALL be ignored (shadow is single-level, no nesting); CLI SHALL clear I_FLAG with no other effect (I_FLAG is already 0).
REQ-022 RETI outside ISR SHALL be ignored.
REQ-023 Interrupt edges arriving in SAVE/VECTOR/ISR/RESTORE SHALL set PENDING and be serviced after returning to IDLE; an edge arriving while PENDING=1 SHALL merge (no count).
REQ-024 An edge detected in the same cycle SAVE clears PENDING SHALL win: PENDING=1 after that edge.
REQ-025 CLI SHALL NOT clear PENDING; a request latched while I_FLAG=0 SHALL be taken on the first boundary after SEI, no earlier than the cycle after I_FLAG reads 1.
REQ-026 Interrupt entry latency: boundary cycle with conditions met -> SHAD_LD next cycle -> INT_TAKEN the cycle after.

Reset
REQ-027 RST_N=0 sampled at a rising edge SHALL force IDLE, I_FLAG=0, PENDING=0, all synchronizer and delay flops 0, and SHAD_LD=INT_TAKEN=FLG_RESTORE=IN_ISR=0 from the following cycle.
REQ-028 Reset SHALL take effect from any state, including mid-SAVE or mid-ISR, with no restore pulse issued.
REQ-029 INTR high during and after reset release SHALL produce one PENDING rise SYNC_STAGES+1 edges after release.

Verification
REQ-030 Basic entry: SYNC_STAGES=2, SEI, INTR pulse of 3 cycles, INSTR_DONE every cycle -> PENDING at edge 3, SHAD_LD 1 cycle, INT_TAKEN next cycle, I_FLAG=0, IN_ISR=1.
REQ-031 Return: in ISR assert RETI&INSTR_DONE -> FLG_RESTORE one cycle, then IDLE, I_FLAG=1, IN_ISR=0.
REQ-032 Masked request: CLI, INTR pulse -> PENDING=1, no SHAD_LD for 20 cycles; SEI -> entry sequence starts at next boundary.
REQ-033 Nesting blocked: in ISR issue SEI then INTR pulse -> I_FLAG stays 0, PENDING=1, no SHAD_LD until after RESTORE, then immediate re-entry.
REQ-034 Priority/edge cases: SEI+CLI same cycle -> I_FLAG=0; RETI in IDLE -> no FLG_RESTORE; edge coincident with SAVE exit -> PENDING=1.
REQ-035 Reset mid-ISR: RST_N=0 one cycle while IN_ISR=1 -> next cycle IDLE, all outputs 0, no FLG_RESTORE ever pulsed.
